byte_word_packer: RTL and testbench

- Upstream neighbour of the byte-lane endian swap stage.
- Accepts a serial stream of BYTE_SIZE-bit bytes over a valid/ready handshake and packs BYTE_COUNT consecutive bytes into one word.
- Lane order per word is little- or big-endian, selected at word start.
- Emits each word with a per-lane keep mask and a last flag. Its output feeds the swap stage directly, or any word-wide consumer.

---
 rtl/byte_word_packer_if.sv | 27 ++
 rtl/byte_word_packer.sv | 86 ++++++++
 tb/tb_byte_word_packer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for the byte_word_packer.
// master = upstream byte source plus downstream word sink; slave = the packer.
interface byte_word_packer_if #(
   parameter int BYTE_COUNT = 4,
   parameter int BYTE_SIZE  = 8
);
   logic                            big_endian;
   logic [BYTE_SIZE-1:0]            s_data;
   logic                            s_valid;
   logic                            s_last;
   logic                            s_ready;
   logic [BYTE_COUNT*BYTE_SIZE-1:0] m_data;
   logic [BYTE_COUNT-1:0]           m_keep;
   logic                            m_last;
   logic                            m_valid;
   logic                            m_ready;

   modport master (
      output big_endian, s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_keep, m_last, m_valid
   );

   modport slave (
      input  big_endian, s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_keep, m_last, m_valid
   );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a serial byte stream into BYTE_COUNT-byte words with per-lane keep
// and a last flag. Lane order is latched on each word's first byte.
// Completed words go to a single output register; the byte side is stalled
// whenever that register is full and not being drained.
module byte_word_packer #(
   parameter int BYTE_COUNT = 4,
   parameter int BYTE_SIZE  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   byte_word_packer_if.slave bus
);
   localparam int CW = $clog2(BYTE_COUNT);
   typedef logic [BYTE_COUNT-1:0][BYTE_SIZE-1:0] word_t;

   word_t                 acc, acc_nxt, word_out, m_data_q;
   logic [BYTE_COUNT-1:0] acc_keep, keep_nxt, m_keep_q;
   logic [CW-1:0]         cnt, lane;
   logic                  ord, eo, xfer, done, s_ready;
   logic                  m_last_q, m_valid_q;

   // Ready depends only on the output register state and m_ready, never on s_valid.
   assign s_ready = rst_n && (!m_valid_q || bus.m_ready);
   assign xfer    = bus.s_valid && s_ready;
   // First byte of a word uses the live order bit; later bytes use the latched one.
   assign eo      = (cnt == '0) ? bus.big_endian : ord;
   assign lane    = eo ? (CW'(BYTE_COUNT-1) - cnt) : cnt;
   assign done    = xfer && ((cnt == CW'(BYTE_COUNT-1)) || bus.s_last);

   // Accumulator and keep mask with the incoming byte merged into its lane.
   always_comb begin
      acc_nxt        = acc;
      acc_nxt[lane]  = bus.s_data;
      keep_nxt       = acc_keep;
      keep_nxt[lane] = 1'b1;
   end

   // Lanes not written in this word are forced to zero in the emitted word.
   for (genvar l = 0; l < BYTE_COUNT; l++) begin : g_lane
      assign word_out[l] = keep_nxt[l] ? acc_nxt[l] : '0;
   end

   // Accumulator, lane mask, byte counter and latched lane order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         acc_keep <= '0;
         cnt      <= '0;
         ord      <= 1'b0;
      end else if (xfer) begin
         if (cnt == '0) ord <= bus.big_endian;
         if (done) begin
            acc      <= '0;
            acc_keep <= '0;
            cnt      <= '0;
         end else begin
            acc      <= acc_nxt;
            acc_keep <= keep_nxt;
            cnt      <= cnt + CW'(1);
         end
      end
   end

   // Output register: reload on word completion, otherwise drain on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_q  <= '0;
         m_keep_q  <= '0;
         m_last_q  <= 1'b0;
         m_valid_q <= 1'b0;
      end else if (done) begin
         m_data_q  <= word_out;
         m_keep_q  <= keep_nxt;
         m_last_q  <= bus.s_last;
         m_valid_q <= 1'b1;
      end else if (m_valid_q && bus.m_ready) begin
         m_valid_q <= 1'b0;
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_data  = m_data_q;
   assign bus.m_keep  = m_keep_q;
   assign bus.m_last  = m_last_q;
   assign bus.m_valid = m_valid_q;
endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer (BYTE_COUNT=4, BYTE_SIZE=8): a table of
// single-word vectors plus hand sequences for stall, streaming, order change
// and reset.
module tb_byte_word_packer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   byte_word_packer_if #(.BYTE_COUNT(4), .BYTE_SIZE(8)) bus ();

   byte_word_packer #(.BYTE_COUNT(4), .BYTE_SIZE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              be;
      int              n;
      logic [3:0][7:0] b;
      bit              last;
      logic [31:0]     d;
      logic [3:0]      k;
      bit              l;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(bit be, int n, logic [31:0] b, bit last,
                               logic [31:0] d, logic [3:0] k, bit l);
      vec_t v;
      v.be = be; v.n = n; v.b = b; v.last = last; v.d = d; v.k = k; v.l = l;
      return v;
   endfunction

   task automatic put(input logic [7:0] d, input bit last);
      bus.s_data  = d;
      bus.s_last  = last;
      bus.s_valid = 1'b1;
   endtask

   task automatic idle();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      v = vecs[idx];
      bus.big_endian = v.be;
      for (int i = 0; i < v.n; i++) begin
         put(v.b[i], v.last && (i == v.n - 1));
         chk($sformatf("v%0d s_ready b%0d", idx, i), 32'(bus.s_ready), 32'd1);
         step();
         if (i < v.n - 1) chk($sformatf("v%0d early m_valid b%0d", idx, i), 32'(bus.m_valid), 32'd0);
      end
      idle();
      chk($sformatf("v%0d m_valid", idx), 32'(bus.m_valid), 32'd1);
      chk($sformatf("v%0d m_data", idx), bus.m_data, v.d);
      chk($sformatf("v%0d m_keep", idx), 32'(bus.m_keep), 32'(v.k));
      chk($sformatf("v%0d m_last", idx), 32'(bus.m_last), 32'(v.l));
      step();
      chk($sformatf("v%0d m_valid drop", idx), 32'(bus.m_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // bytes listed high-index first: b[0] is the first byte sent
      vecs[0] = mk(1'b0, 4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111, 1'b0);
      vecs[1] = mk(1'b1, 4, 32'h44332211, 1'b0, 32'h11223344, 4'b1111, 1'b0);
      vecs[2] = mk(1'b0, 2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'b0011, 1'b1);
      vecs[3] = mk(1'b1, 2, 32'h0000BBAA, 1'b1, 32'hAABB0000, 4'b1100, 1'b1);
      vecs[4] = mk(1'b0, 1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001, 1'b1);
      vecs[5] = mk(1'b1, 1, 32'h0000005A, 1'b1, 32'h5A000000, 4'b1000, 1'b1);
      vecs[6] = mk(1'b0, 4, 32'h04030201, 1'b1, 32'h04030201, 4'b1111, 1'b1);
      vecs[7] = mk(1'b1, 3, 32'h00030201, 1'b1, 32'h01020300, 4'b1110, 1'b1);

      bus.big_endian = 1'b0;
      bus.s_data     = 8'h00;
      bus.s_valid    = 1'b1;
      bus.s_last     = 1'b0;
      bus.m_ready    = 1'b1;
      #12;
      // reset state
      chk("rst s_ready", 32'(bus.s_ready), 32'd0);
      chk("rst m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst m_data", bus.m_data, 32'd0);
      chk("rst m_keep", 32'(bus.m_keep), 32'd0);
      chk("rst m_last", 32'(bus.m_last), 32'd0);
      idle();
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_vec(i);

      // big_endian change mid-word is ignored until the next word
      bus.big_endian = 1'b0;
      put(8'h11, 1'b0); step();
      bus.big_endian = 1'b1;
      put(8'h22, 1'b0); step();
      put(8'h33, 1'b0); step();
      put(8'h44, 1'b0); step();
      idle();
      chk("ordchg w0 data", bus.m_data, 32'h44332211);
      put(8'h55, 1'b1); step();
      idle();
      chk("ordchg w1 data", bus.m_data, 32'h55000000);
      chk("ordchg w1 keep", 32'(bus.m_keep), 32'b1000);
      step();

      // backpressure: stall 5 cycles after the first word
      bus.big_endian = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         put(8'(i), 1'b0);
         step();
      end
      chk("bp w0 m_valid", 32'(bus.m_valid), 32'd1);
      chk("bp w0 m_data", bus.m_data, 32'h04030201);
      bus.m_ready = 1'b0;
      put(8'h05, 1'b0);
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp stall s_ready c%0d", c), 32'(bus.s_ready), 32'd0);
         chk($sformatf("bp stall m_data c%0d", c), bus.m_data, 32'h04030201);
         step();
      end
      chk("bp stall m_valid", 32'(bus.m_valid), 32'd1);
      bus.m_ready = 1'b1;
      #1;
      chk("bp release s_ready", 32'(bus.s_ready), 32'd1);
      step();
      chk("bp after drain m_valid", 32'(bus.m_valid), 32'd0);
      for (int i = 6; i <= 8; i++) begin
         put(8'(i), 1'b0);
         step();
      end
      idle();
      chk("bp w1 m_valid", 32'(bus.m_valid), 32'd1);
      chk("bp w1 m_data", bus.m_data, 32'h08070605);
      chk("bp w1 m_keep", 32'(bus.m_keep), 32'b1111);
      step();
      chk("bp w1 m_valid drop", 32'(bus.m_valid), 32'd0);

      // back-to-back: 12 bytes, no bubbles
      for (int i = 0; i < 12; i++) begin
         put(8'(8'h21 + i), 1'b0);
         chk($sformatf("b2b s_ready %0d", i), 32'(bus.s_ready), 32'd1);
         step();
         chk($sformatf("b2b m_valid %0d", i), 32'(bus.m_valid), 32'((i % 4) == 3));
         if ((i % 4) == 3) begin
            logic [31:0] e;
            e = {8'(8'h21 + i), 8'(8'h20 + i), 8'(8'h1F + i), 8'(8'h1E + i)};
            chk($sformatf("b2b m_data %0d", i), bus.m_data, e);
         end
      end
      idle();
      step();

      // reset mid-word, asserted away from the clock edge
      put(8'h01, 1'b0); step();
      put(8'h02, 1'b0); step();
      put(8'h03, 1'b1); // offered but held off by reset
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst s_ready", 32'(bus.s_ready), 32'd0);
      chk("midrst m_valid", 32'(bus.m_valid), 32'd0);
      chk("midrst m_data", bus.m_data, 32'd0);
      chk("midrst m_keep", 32'(bus.m_keep), 32'd0);
      step();
      rst_n = 1'b1;
      chk("midrst held m_valid", 32'(bus.m_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         put(8'(8'h10 + i), 1'b0);
         step();
      end
      idle();
      chk("postrst m_valid", 32'(bus.m_valid), 32'd1);
      chk("postrst m_data", bus.m_data, 32'h13121110);
      chk("postrst m_keep", 32'(bus.m_keep), 32'b1111);
      chk("postrst m_last", 32'(bus.m_last), 32'd0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
